uart_tx: RTL and testbench

8-bit UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, no parity, 1 stop bit). It is the transmit-side counterpart of the team's 8-bit no-parity UART receiver and uses the same per-bit clock-count timing scheme. It sends results from the neural-network datapath to the host over a serial line. A one-entry holding register lets the next byte be queued during a frame, so consecutive frames go out with no idle gap.

---
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
module uart_tx #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(CLK_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] clk_count, clk_count_n;
    logic [2:0]  bit_index, bit_index_n;
    logic [7:0]  shift_reg, shift_reg_n;
    logic [7:0]  hold_data, hold_data_n;
    logic        hold_full, hold_full_n;
    logic        tx_n, busy_n, done_n;
    logic        accept, count_end, load_held, load_direct;

    // A full holding register always blocks new bytes, so a held load and a
    // direct load can never coincide.
    assign in_ready  = enable && !hold_full && !rst;
    assign accept    = in_valid && in_ready;
    assign count_end = (clk_count == LAST_COUNT);

    // State and datapath registers; reset returns the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_count <= 16'd0;
            bit_index <= 3'd0;
            shift_reg <= 8'd0;
            hold_data <= 8'd0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            clk_count <= clk_count_n;
            bit_index <= bit_index_n;
            shift_reg <= shift_reg_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state, bit timing, loading decisions and registered-output values.
    always_comb begin
        state_n     = state;
        clk_count_n = clk_count;
        bit_index_n = bit_index;
        shift_reg_n = shift_reg;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        done_n      = 1'b0;
        load_held   = 1'b0;
        load_direct = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full && enable) begin
                    load_held = 1'b1;
                end else if (accept) begin
                    load_direct = 1'b1;
                end
            end
            START: begin
                if (count_end) begin
                    state_n     = DATA;
                    bit_index_n = 3'd0;
                    clk_count_n = 16'd0;
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (count_end) begin
                    clk_count_n = 16'd0;
                    if (bit_index == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_index_n = bit_index + 3'd1;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            STOP: begin
                if (count_end) begin
                    done_n = 1'b1;
                    if (hold_full && enable) begin
                        load_held = 1'b1;
                    end else if (accept) begin
                        load_direct = 1'b1;
                    end else begin
                        state_n     = IDLE;
                        clk_count_n = 16'd0;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            default: begin
                state_n     = IDLE;
                clk_count_n = 16'd0;
            end
        endcase

        // Bytes accepted mid-frame park in the holding register.
        if (accept && !load_direct) begin
            hold_data_n = data_in;
            hold_full_n = 1'b1;
        end

        if (load_held) begin
            shift_reg_n = hold_data;
            hold_full_n = 1'b0;
            state_n     = START;
            clk_count_n = 16'd0;
        end

        if (load_direct) begin
            shift_reg_n = data_in;
            state_n     = START;
            clk_count_n = 16'd0;
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_reg_n[bit_index_n];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       enable_a, valid_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       enable_b, valid_b, ready_b, tx_b, busy_b, done_b;
    logic [7:0] data_b;

    int tests = 0;
    int fails = 0;

    uart_tx #(.CLK_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .data_in(data_a),
        .in_valid(valid_a), .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx #(.CLK_PER_BIT(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .data_in(data_b),
        .in_valid(valid_b), .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line value of bit slot k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line decoder for dut_b: two cycles per bit, both cycles must agree.
    int         dec_cyc = -1;
    int         dec_idx = 0;
    int         dec_errors = 0;
    int         done_cnt_b = 0;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] dec_q[$];

    always @(negedge clk) begin
        if (done_b === 1'b1) done_cnt_b++;
        if (rst) begin
            dec_cyc = -1;
        end else if (dec_cyc < 0) begin
            if (tx_b === 1'b0) dec_cyc = 0;
        end else begin
            dec_cyc++;
            if (dec_cyc < 2) begin
                if (tx_b !== 1'b0) dec_errors++;
            end else if (dec_cyc < 18) begin
                dec_idx = (dec_cyc - 2) / 2;
                if (dec_cyc % 2 == 0) dec_byte[dec_idx] = tx_b;
                else if (dec_byte[dec_idx] !== tx_b) dec_errors++;
            end else begin
                if (tx_b !== 1'b1) dec_errors++;
                if (dec_cyc == 19) begin
                    dec_q.push_back(dec_byte);
                    dec_cyc = -1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done_a); end
        tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst got %b want 0", ready_a); end
        tests++; if (tx_b !== 1'b1) begin fails++; $display("FAIL reset_tx_b got %b want 1", tx_b); end
        rst = 1'b0;
        #1;
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready_after got %b want 1", ready_a); end
        tick();
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       exp_tx;
        b = 8'hA5;
        data_a  = b;
        valid_a = 1'b1;
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL single_pre_tx got %b want 1", tx_a); end
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL single_pre_ready got %b want 1", ready_a); end
        tick();
        valid_a = 1'b0;
        for (int k = 0; k < 42; k++) begin
            exp_tx = (k < 40) ? frame_bit(b, k / 4) : 1'b1;
            tests++; if (tx_a !== exp_tx) begin fails++; $display("FAIL single_tx k=%0d got %b want %b", k, tx_a, exp_tx); end
            tests++; if (busy_a !== (k < 40)) begin fails++; $display("FAIL single_busy k=%0d got %b want %b", k, busy_a, (k < 40)); end
            tests++; if (done_a !== (k == 40)) begin fails++; $display("FAIL single_done k=%0d got %b want %b", k, done_a, (k == 40)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_tx, exp_ready;
        data_a  = 8'h00;
        valid_a = 1'b1;
        tick();
        for (int k = 0; k < 82; k++) begin
            if (k < 40)      exp_tx = frame_bit(8'h00, k / 4);
            else if (k < 80) exp_tx = frame_bit(8'hFF, (k - 40) / 4);
            else             exp_tx = 1'b1;
            exp_ready = (k == 0) || (k >= 40);
            tests++; if (tx_a !== exp_tx) begin fails++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx_a, exp_tx); end
            tests++; if (ready_a !== exp_ready) begin fails++; $display("FAIL b2b_ready k=%0d got %b want %b", k, ready_a, exp_ready); end
            tests++; if (done_a !== (k == 40 || k == 80)) begin fails++; $display("FAIL b2b_done k=%0d got %b", k, done_a); end
            tests++; if (busy_a !== (k < 80)) begin fails++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy_a, (k < 80)); end
            if (k == 0) data_a = 8'hFF;
            if (k == 1) valid_a = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        data_a  = 8'h3C;
        valid_a = 1'b1;
        tick();
        data_a = 8'h99;
        tick();
        valid_a = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got %b want 1", busy_a); end
        tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL rstmid_held_ready got %b want 0", ready_a); end
        #1 rst = 1'b1;
        #1;
        tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL rstmid_async_tx got %b want 1", tx_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rstmid_async_busy got %b want 0", busy_a); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL rstmid_ready_after got %b want 1", ready_a); end
        for (int k = 0; k < 60; k++) begin
            tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                fails++; $display("FAIL rstmid_quiet k=%0d tx=%b busy=%b done=%b want 1/0/0", k, tx_a, busy_a, done_a);
            end
            tick();
        end
    endtask

    task automatic test_enable_mid_frame();
        logic exp_tx, exp_busy, exp_ready;
        data_a  = 8'h5A;
        valid_a = 1'b1;
        tick();
        for (int k = 0; k < 104; k++) begin
            if (k < 40)                 exp_tx = frame_bit(8'h5A, k / 4);
            else if (k >= 61 && k < 101) exp_tx = frame_bit(8'hC3, (k - 61) / 4);
            else                        exp_tx = 1'b1;
            exp_busy  = (k < 40) || (k >= 61 && k < 101);
            exp_ready = (k == 0) || (k >= 61);
            tests++; if (tx_a !== exp_tx) begin fails++; $display("FAIL en_tx k=%0d got %b want %b", k, tx_a, exp_tx); end
            tests++; if (busy_a !== exp_busy) begin fails++; $display("FAIL en_busy k=%0d got %b want %b", k, busy_a, exp_busy); end
            tests++; if (ready_a !== exp_ready) begin fails++; $display("FAIL en_ready k=%0d got %b want %b", k, ready_a, exp_ready); end
            tests++; if (done_a !== (k == 40 || k == 101)) begin fails++; $display("FAIL en_done k=%0d got %b", k, done_a); end
            if (k == 0) data_a = 8'hC3;
            if (k == 1) valid_a = 1'b0;
            if (k == 10) enable_a = 1'b0;
            if (k == 60) enable_a = 1'b1;
            tick();
        end
    endtask

    task automatic test_enable_idle();
        enable_a = 1'b0;
        valid_a  = 1'b1;
        data_a   = 8'h77;
        #1;
        for (int k = 0; k < 20; k++) begin
            tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL idle_dis_ready k=%0d got %b want 0", k, ready_a); end
            tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL idle_dis_line k=%0d tx=%b busy=%b want 1/0", k, tx_a, busy_a); end
            tick();
        end
        valid_a  = 1'b0;
        enable_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL idle_reen_line k=%0d tx=%b busy=%b want 1/0", k, tx_a, busy_a); end
            tick();
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] sent_q[$];
        int         done_base, budget, gap;
        bit         timed_out;
        done_base = done_cnt_b;
        timed_out = 0;
        for (int i = 0; i < 64 && !timed_out; i++) begin
            data_b  = 8'($urandom);
            valid_b = 1'b1;
            budget  = 0;
            forever begin
                if (ready_b === 1'b1) begin
                    sent_q.push_back(data_b);
                    tick();
                    break;
                end
                tick();
                budget++;
                if (budget > 200) begin timed_out = 1; break; end
            end
            valid_b = 1'b0;
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
            for (int g = 0; g < gap; g++) tick();
        end
        valid_b = 1'b0;
        tests++; if (timed_out) begin fails++; $display("FAIL rand_accept_timeout sent=%0d want 64", sent_q.size()); end
        budget = 0;
        while (dec_q.size() < sent_q.size() && budget < 3000) begin
            tick();
            budget++;
        end
        for (int k = 0; k < 5; k++) tick();
        tests++; if (sent_q.size() != 64) begin fails++; $display("FAIL rand_sent_count got %0d want 64", sent_q.size()); end
        tests++; if (dec_q.size() != sent_q.size()) begin fails++; $display("FAIL rand_decoded_count got %0d want %0d", dec_q.size(), sent_q.size()); end
        for (int i = 0; i < sent_q.size() && i < dec_q.size(); i++) begin
            tests++; if (dec_q[i] !== sent_q[i]) begin fails++; $display("FAIL rand_byte i=%0d got %h want %h", i, dec_q[i], sent_q[i]); end
        end
        tests++; if (dec_errors != 0) begin fails++; $display("FAIL rand_line_shape got %0d errors want 0", dec_errors); end
        tests++; if (done_cnt_b - done_base != 64) begin fails++; $display("FAIL rand_done_count got %0d want 64", done_cnt_b - done_base); end
        tests++; if (busy_b !== 1'b0 || tx_b !== 1'b1) begin fails++; $display("FAIL rand_final_idle busy=%b tx=%b want 0/1", busy_b, tx_b); end
    endtask

    initial begin
        rst      = 1'b1;
        enable_a = 1'b1;
        valid_a  = 1'b0;
        data_a   = 8'h00;
        enable_b = 1'b1;
        valid_b  = 1'b0;
        data_b   = 8'h00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_mid_frame();
        test_enable_idle();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
